// File: rtl/fetch_sequencer_if.sv
// Bundles the sequencer's control, Fetch_Unit and IF/ID signals.
// Rev 1.0 - initial release
`default_nettype none

interface fetch_sequencer_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic               go;
  logic               stall;
  logic               halt_req;
  logic               br_valid;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    fu_pc_out;
  logic [INSTR_W-1:0] fu_instr;
  logic [PC_W-1:0]    fu_pc_in;
  logic               fu_start;
  logic               fu_branch;
  logic               fu_taken;
  logic [PC_W-1:0]    fu_target;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               id_valid;
  logic               flush;
  logic               done;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [CNT_W-1:0]   redirect_cnt;

  modport master (
    output go, stall, halt_req, br_valid, br_taken, br_target, fu_pc_out, fu_instr,
    input  fu_pc_in, fu_start, fu_branch, fu_taken, fu_target,
    input  id_instr, id_pc, id_valid, flush, done, fetch_cnt, redirect_cnt
  );

  modport slave (
    input  go, stall, halt_req, br_valid, br_taken, br_target, fu_pc_out, fu_instr,
    output fu_pc_in, fu_start, fu_branch, fu_taken, fu_target,
    output id_instr, id_pc, id_valid, flush, done, fetch_cnt, redirect_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, sequences the Fetch_Unit, drives the IF/ID latch.
// Rev 1.0 - initial release
`default_nettype none

module fetch_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 9,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int              FLUSH_CYC = 2,
  parameter int              CNT_W     = 16
) (
  input  wire               clk,
  input  wire               reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;
  logic [1:0]         flush_cnt_q, flush_cnt_d;
  logic               fu_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= START_PC;
      id_instr_q     <= '0;
      id_pc_q        <= '0;
      id_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      id_instr_q     <= id_instr_d;
      id_pc_q        <= id_pc_d;
      id_valid_q     <= id_valid_d;
      done_q         <= done_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_valid_d     = id_valid_q;
    done_d         = done_q;
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    fu_start       = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.go) begin
          fu_start = 1'b1;
          pc_d     = START_PC;
          done_d   = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Priority: taken branch > halt > stall > advance.
        if (bus.br_valid && bus.br_taken) begin
          pc_d           = bus.fu_pc_out;
          id_valid_d     = 1'b0;
          flush_cnt_d    = 2'(FLUSH_CYC - 1);
          redirect_cnt_d = (&redirect_cnt_q) ? redirect_cnt_q : redirect_cnt_q + CNT_W'(1);
          state_d        = S_FLUSH;
        end else if (bus.halt_req) begin
          id_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_HALT;
        end else if (!bus.stall) begin
          id_instr_d  = bus.fu_instr;
          id_pc_d     = pc_q;
          id_valid_d  = 1'b1;
          pc_d        = bus.fu_pc_out;
          fetch_cnt_d = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 2'd0) begin
          state_d = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.fu_pc_in     = pc_q;
  assign bus.fu_start     = fu_start;
  assign bus.fu_branch    = bus.br_valid & (state_q == S_RUN);
  assign bus.fu_taken     = bus.br_taken & bus.fu_branch;
  assign bus.fu_target    = bus.br_target;
  assign bus.id_instr     = id_instr_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.flush        = (state_q == S_FLUSH);
  assign bus.done         = done_q;
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (START_PC 0 and FFFE) against a behavioural model.
// Rev 1.0 - initial release
`default_nettype none

module tb_fetch_sequencer;
  localparam int PC_W = 16, INSTR_W = 9, CNT_W = 16, FC = 2;

  logic clk = 1'b0;
  logic reset, go, stall, halt_req, br_valid, br_taken;
  logic [PC_W-1:0] br_target;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] imem(input logic [PC_W-1:0] a);
    return a[INSTR_W-1:0] ^ 9'h155;
  endfunction

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus0 ();
  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus1 ();

  assign bus0.go = go;            assign bus1.go = go;
  assign bus0.stall = stall;      assign bus1.stall = stall;
  assign bus0.halt_req = halt_req; assign bus1.halt_req = halt_req;
  assign bus0.br_valid = br_valid; assign bus1.br_valid = br_valid;
  assign bus0.br_taken = br_taken; assign bus1.br_taken = br_taken;
  assign bus0.br_target = br_target; assign bus1.br_target = br_target;
  // Fetch_Unit behaviour
  assign bus0.fu_pc_out = (bus0.fu_branch & bus0.fu_taken) ? bus0.fu_target : bus0.fu_pc_in + 16'd1;
  assign bus1.fu_pc_out = (bus1.fu_branch & bus1.fu_taken) ? bus1.fu_target : bus1.fu_pc_in + 16'd1;
  assign bus0.fu_instr = imem(bus0.fu_pc_in);
  assign bus1.fu_instr = imem(bus1.fu_pc_in);

  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .START_PC(16'h0000), .FLUSH_CYC(FC), .CNT_W(CNT_W))
    u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .START_PC(16'hFFFE), .FLUSH_CYC(FC), .CNT_W(CNT_W))
    u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: "running" covers both fetching and flushing; flush_left counts flush cycles.
  logic [PC_W-1:0]    c_start [2] = '{16'h0000, 16'hFFFE};
  bit                 m_run   [2];
  int                 m_flush [2];
  logic [PC_W-1:0]    m_pc    [2];
  logic [INSTR_W-1:0] m_instr [2];
  logic [PC_W-1:0]    m_idpc  [2];
  bit                 m_idv   [2];
  bit                 m_done  [2];
  logic [CNT_W-1:0]   m_fcnt  [2];
  logic [CNT_W-1:0]   m_rcnt  [2];

  task automatic model_reset(input int k);
    m_run[k] = 0; m_flush[k] = 0; m_pc[k] = c_start[k];
    m_instr[k] = '0; m_idpc[k] = '0; m_idv[k] = 0; m_done[k] = 0;
    m_fcnt[k] = '0; m_rcnt[k] = '0;
  endtask

  task automatic model_step(input int k);
    if (reset) model_reset(k);
    else if (m_flush[k] > 0) m_flush[k]--;
    else if (m_run[k]) begin
      if (br_valid && br_taken) begin
        m_pc[k] = br_target; m_idv[k] = 0; m_flush[k] = FC;
        if (m_rcnt[k] != '1) m_rcnt[k]++;
      end else if (halt_req) begin
        m_idv[k] = 0; m_done[k] = 1; m_run[k] = 0;
      end else if (!stall) begin
        m_instr[k] = imem(m_pc[k]); m_idpc[k] = m_pc[k]; m_idv[k] = 1;
        m_pc[k] = m_pc[k] + 16'd1;
        if (m_fcnt[k] != '1) m_fcnt[k]++;
      end
    end else if (go) begin
      m_pc[k] = c_start[k]; m_run[k] = 1; m_done[k] = 0;
    end
  endtask

  task automatic cmp(input int k, input logic [PC_W-1:0] pc_in, input logic st, input logic fb,
                     input logic ft, input logic [PC_W-1:0] tg, input logic [INSTR_W-1:0] ii,
                     input logic [PC_W-1:0] ip, input logic iv, input logic fl, input logic dn,
                     input logic [CNT_W-1:0] fc, input logic [CNT_W-1:0] rc);
    logic exp_fb;
    exp_fb = br_valid && m_run[k] && (m_flush[k] == 0);
    chk($sformatf("u%0d.fu_pc_in", k), 32'(pc_in), 32'(m_pc[k]));
    chk($sformatf("u%0d.fu_start", k), 32'(st), 32'(go && !m_run[k]));
    chk($sformatf("u%0d.fu_branch", k), 32'(fb), 32'(exp_fb));
    chk($sformatf("u%0d.fu_taken", k), 32'(ft), 32'(exp_fb && br_taken));
    chk($sformatf("u%0d.fu_target", k), 32'(tg), 32'(br_target));
    chk($sformatf("u%0d.id_instr", k), 32'(ii), 32'(m_instr[k]));
    chk($sformatf("u%0d.id_pc", k), 32'(ip), 32'(m_idpc[k]));
    chk($sformatf("u%0d.id_valid", k), 32'(iv), 32'(m_idv[k]));
    chk($sformatf("u%0d.flush", k), 32'(fl), 32'(m_flush[k] > 0));
    chk($sformatf("u%0d.done", k), 32'(dn), 32'(m_done[k]));
    chk($sformatf("u%0d.fetch_cnt", k), 32'(fc), 32'(m_fcnt[k]));
    chk($sformatf("u%0d.redirect_cnt", k), 32'(rc), 32'(m_rcnt[k]));
  endtask

  // Compare at the falling edge, then advance the model to the next rising edge.
  initial begin
    model_reset(0); model_reset(1);
    forever begin
      @(negedge clk);
      cmp(0, bus0.fu_pc_in, bus0.fu_start, bus0.fu_branch, bus0.fu_taken, bus0.fu_target,
          bus0.id_instr, bus0.id_pc, bus0.id_valid, bus0.flush, bus0.done, bus0.fetch_cnt, bus0.redirect_cnt);
      cmp(1, bus1.fu_pc_in, bus1.fu_start, bus1.fu_branch, bus1.fu_taken, bus1.fu_target,
          bus1.id_instr, bus1.id_pc, bus1.id_valid, bus1.flush, bus1.done, bus1.fetch_cnt, bus1.redirect_cnt);
      model_step(0); model_step(1);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; go = 0; stall = 0; halt_req = 0; br_valid = 0; br_taken = 0; br_target = '0;
    tick(); tick();
    reset = 0;
    repeat (5) tick();
    chk("rst.fu_pc_in", 32'(bus0.fu_pc_in), 32'h0);
    chk("rst.id_valid", 32'(bus0.id_valid), 32'h0);
    chk("rst.done", 32'(bus0.done), 32'h0);
    chk("rst.fetch_cnt", 32'(bus0.fetch_cnt), 32'h0);

    go = 1; #1;
    chk("go.fu_start", 32'(bus0.fu_start), 32'h1);
    tick(); go = 0; #1;
    chk("go.fu_start_drop", 32'(bus0.fu_start), 32'h0);
    tick(); chk("seq.id_pc0", 32'(bus0.id_pc), 32'h0);
    tick(); chk("seq.id_pc1", 32'(bus0.id_pc), 32'h1);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.id_pc", 32'(bus0.id_pc), 32'h1);
      chk("stall.pc", 32'(bus0.fu_pc_in), 32'h2);
    end
    stall = 0;
    tick(); chk("seq.id_pc2", 32'(bus0.id_pc), 32'h2);
    tick(); chk("seq.id_pc3", 32'(bus0.id_pc), 32'h3);
    chk("seq.fetch_cnt", 32'(bus0.fetch_cnt), 32'h4);

    br_valid = 1; br_taken = 1; br_target = 16'h0010;
    tick(); br_valid = 0; br_taken = 0;
    chk("br.flush1", 32'(bus0.flush), 32'h1);
    chk("br.id_valid", 32'(bus0.id_valid), 32'h0);
    tick(); chk("br.flush2", 32'(bus0.flush), 32'h1);
    tick(); chk("br.flush_end", 32'(bus0.flush), 32'h0);
    chk("br.pc", 32'(bus0.fu_pc_in), 32'h10);
    tick(); chk("br.id_pc_tgt", 32'(bus0.id_pc), 32'h10);
    tick(); chk("br.id_pc_tgt1", 32'(bus0.id_pc), 32'h11);
    chk("br.redirect_cnt", 32'(bus0.redirect_cnt), 32'h1);

    br_valid = 1; br_taken = 0; #1;
    chk("nt.fu_branch", 32'(bus0.fu_branch), 32'h1);
    chk("nt.fu_taken", 32'(bus0.fu_taken), 32'h0);
    tick(); br_valid = 0;
    chk("nt.id_pc", 32'(bus0.id_pc), 32'h12);
    chk("nt.flush", 32'(bus0.flush), 32'h0);

    halt_req = 1; stall = 1;
    tick(); halt_req = 0; stall = 0;
    chk("halt.done", 32'(bus0.done), 32'h1);
    chk("halt.id_valid", 32'(bus0.id_valid), 32'h0);
    repeat (3) tick();
    chk("halt.pc_frozen", 32'(bus0.fu_pc_in), 32'h13);
    chk("halt.id_pc", 32'(bus0.id_pc), 32'h12);
    go = 1; #1;
    chk("halt.fu_start", 32'(bus0.fu_start), 32'h1);
    tick(); go = 0;
    chk("restart.done", 32'(bus0.done), 32'h0);
    chk("restart.pc", 32'(bus0.fu_pc_in), 32'h0);

    br_valid = 1; br_taken = 1; br_target = 16'h0020;
    tick(); br_valid = 0; br_taken = 0;
    chk("midflush.flush", 32'(bus0.flush), 32'h1);
    reset = 1;
    tick(); reset = 0;
    chk("midrst.flush", 32'(bus0.flush), 32'h0);
    chk("midrst.pc", 32'(bus0.fu_pc_in), 32'h0);
    chk("midrst.redirect_cnt", 32'(bus0.redirect_cnt), 32'h0);
    chk("midrst.fetch_cnt", 32'(bus0.fetch_cnt), 32'h0);
    chk("midrst.id_pc", 32'(bus0.id_pc), 32'h0);
    chk("midrst.u1_pc", 32'(bus1.fu_pc_in), 32'hFFFE);

    go = 1; tick(); go = 0;
    tick(); chk("wrap.id_pc0", 32'(bus1.id_pc), 32'hFFFE);
    tick(); chk("wrap.id_pc1", 32'(bus1.id_pc), 32'hFFFF);
    tick(); chk("wrap.id_pc2", 32'(bus1.id_pc), 32'h0000);
    tick(); chk("wrap.id_pc3", 32'(bus1.id_pc), 32'h0001);

    br_valid = 1; br_taken = 1; br_target = 16'h0030; halt_req = 1;
    tick(); br_valid = 0; br_taken = 0; halt_req = 0;
    chk("brhalt.flush", 32'(bus1.flush), 32'h1);
    chk("brhalt.done", 32'(bus1.done), 32'h0);
    repeat (4) tick();
    chk("brhalt.id_pc", 32'(bus1.id_pc), 32'h31);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
